// File: rtl/darkaxi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : darkaxi_bridge                                               |
// | Description : Converts the darkriscv stall-based data bus into single-beat |
// |               AXI4 transactions (64-bit data, ADDR_W-bit address). One      |
// |               transaction is outstanding at a time; the core is stalled    |
// |               through XHLT until the response has been accepted.           |
// | Ports       : CLK/RESN        clock, synchronous active-low reset          |
// |               XADDR..XDATAO   core request (address, rd/wr, be, wdata)     |
// |               XDATAI, XHLT    read data to core, stall to core             |
// |               ERR             sticky error flag (any non-OKAY response)    |
// |               aw*/w*/b*       AXI4 write address, data, response channels  |
// |               ar*/r*          AXI4 read address and data channels          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module darkaxi_bridge #(
  parameter logic [3:0] AXI_ID = 4'h0,
  parameter int         ADDR_W = 29,
  parameter int         DATA_W = 64
) (
  input  logic                  CLK,
  input  logic                  RESN,
  // core side
  input  logic [31:0]           XADDR,
  input  logic                  XRD,
  input  logic                  XWR,
  input  logic [3:0]            XBE,
  input  logic [31:0]           XDATAO,
  output logic [31:0]           XDATAI,
  output logic                  XHLT,
  output logic                  ERR,
  // write address channel
  output logic [3:0]            awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic [3:0]            awqos,
  output logic                  awvalid,
  input  logic                  awready,
  // write data channel
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // write response channel
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  // read address channel
  output logic [3:0]            arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic [3:0]            arqos,
  output logic                  arvalid,
  input  logic                  arready,
  // read data channel
  input  logic [3:0]            rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  // word address only: bit 0 of addr_q is XADDR[2], the 32-bit lane select
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        be_q, be_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              w_aw_fire;
  logic              w_w_fire;

  // bus id, rlast and the address bits outside the AXI window carry no
  // information for a single-beat, single-outstanding master
  logic              w_unused;
  assign w_unused = ^{bid, rid, rlast, XADDR[31:ADDR_W], XADDR[1:0]};

  // fixed single-beat, 32-bit, INCR attributes
  assign awid    = AXI_ID;
  assign awlen   = 8'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awqos   = 4'd0;
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arqos   = 4'd0;
  assign wlast   = 1'b1;

  // payload comes only from latched registers, so it is stable while valid
  assign awaddr = {addr_q, 2'b00};
  assign araddr = {addr_q, 2'b00};
  assign wdata  = {data_q, data_q};
  assign wstrb  = addr_q[0] ? {be_q, 4'h0} : {4'h0, be_q};

  // AW and W are independent: each drops as soon as its own handshake is done
  assign awvalid = (state_q == S_WADDR) && !aw_done_q;
  assign wvalid  = (state_q == S_WADDR) && !w_done_q;
  assign bready  = (state_q == S_WRESP);
  assign arvalid = (state_q == S_RADDR);
  assign rready  = (state_q == S_RDATA);

  assign w_aw_fire = awvalid && awready;
  assign w_w_fire  = wvalid && wready;

  // stall as soon as a request shows up in IDLE; release only in DONE
  assign XHLT   = (state_q == S_IDLE) ? (XWR || XRD) : (state_q != S_DONE);
  assign XDATAI = rdata_q;
  assign ERR    = err_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (XWR || XRD) begin
          addr_d  = XADDR[ADDR_W-1:2];
          data_d  = XDATAO;
          be_d    = XBE;
          // a simultaneous read and write request resolves to the write
          state_d = XWR ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        aw_done_d = aw_done_q || w_aw_fire;
        w_done_d  = w_done_q || w_w_fire;
        if (aw_done_d && w_done_d) begin
          state_d   = S_WRESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_WRESP: begin
        if (bvalid) begin
          state_d = S_DONE;
          if (bresp != 2'b00) err_d = 1'b1;
        end
      end
      S_RADDR: begin
        if (arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (rvalid) begin
          rdata_d = addr_q[0] ? rdata[63:32] : rdata[31:0];
          if (rresp != 2'b00) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // requests still asserted here belong to the finished access
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESN) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_darkaxi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_darkaxi_bridge                                            |
// | Description : Bench for darkaxi_bridge. A core driver issues accesses, an  |
// |               AXI slave with its own 64-bit memory answers them, and a     |
// |               byte-addressed reference memory predicts read data.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_darkaxi_bridge;

  logic        CLK, RESN;
  logic [31:0] XADDR, XDATAO, XDATAI;
  logic        XRD, XWR, XHLT, ERR;
  logic [3:0]  XBE;
  logic [3:0]  awid, awcache, awqos, arid, arcache, arqos, bid, rid;
  logic [28:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arlock, arvalid, arready, rlast, rvalid, rready;
  logic [63:0] wdata, rdata;

  darkaxi_bridge #(.AXI_ID(4'h0), .ADDR_W(29), .DATA_W(64)) dut (
    .CLK(CLK), .RESN(RESN),
    .XADDR(XADDR), .XRD(XRD), .XWR(XWR), .XBE(XBE), .XDATAO(XDATAO),
    .XDATAI(XDATAI), .XHLT(XHLT), .ERR(ERR),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model: byte memory, sticky error ----------------
  logic [7:0]  rmem [0:255];
  bit          err_exp;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {rmem[b + 8'd3], rmem[b + 8'd2], rmem[b + 8'd1], rmem[b]};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    for (int i = 0; i < 4; i++)
      if (be[i]) rmem[b + 8'(i)] = d[8*i +: 8];
  endtask

  // current core request, visible to the slave for address/payload checks
  bit          cur_wr, cur_rd;
  logic [31:0] cur_addr, cur_data;
  logic [3:0]  cur_be;

  // ---------------- AXI slave with its own 64-bit memory ----------------------
  logic [63:0] smem [0:31];
  int          mode;          // 0: always ready, immediate responses; 1: random
  bit          slv_rst, b_hold, r_force_en;
  logic [63:0] r_force_data;
  logic [1:0]  force_rresp;
  int          aw_stall;
  int          aw_hi, w_hi, n_b, n_aw, n_ar;

  initial begin
    bit          have_aw, have_w, pend_ar, b_fire, r_fire;
    bit          aw_wait, w_wait, ar_wait;
    logic [28:0] s_awaddr, s_araddr, aw_prev, ar_prev;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic [71:0] w_prev;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0; bid = 0; rid = 0; rlast = 1'b1;
    have_aw = 0; have_w = 0; pend_ar = 0; b_fire = 0; r_fire = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    s_awaddr = 0; s_araddr = 0; aw_prev = 0; ar_prev = 0; s_wdata = 0; s_wstrb = 0; w_prev = 0;
    forever begin
      @(negedge CLK);
      if (slv_rst) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        have_aw = 0; have_w = 0; pend_ar = 0; b_fire = 0; r_fire = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        continue;
      end
      // retire handshakes that completed on the edge just passed
      if (b_fire) begin bvalid = 0; b_fire = 0; n_b++; end
      if (r_fire) begin rvalid = 0; r_fire = 0; end
      // a valid that was not accepted must stay up with unchanged payload
      if (aw_wait) chk("aw_stable", {awvalid, awaddr}, {1'b1, aw_prev});
      if (w_wait)  chk("w_stable", {wvalid, wdata, wstrb}, {1'b1, w_prev});
      if (ar_wait) chk("ar_stable", {arvalid, araddr}, {1'b1, ar_prev});
      // responses only for address/data handshakes already completed
      if (have_aw && have_w && !bvalid && !b_hold && (mode == 0 || $urandom_range(0, 2) == 0)) begin
        for (int i = 0; i < 8; i++)
          if (s_wstrb[i]) smem[s_awaddr[7:3]][8*i +: 8] = s_wdata[8*i +: 8];
        bresp   = (mode == 1 && $urandom_range(0, 11) == 0) ? 2'b10 : 2'b00;
        bvalid  = 1;
        have_aw = 0;
        have_w  = 0;
      end
      if (pend_ar && !rvalid && (mode == 0 || $urandom_range(0, 2) == 0)) begin
        rdata   = r_force_en ? r_force_data : smem[s_araddr[7:3]];
        rresp   = (force_rresp != 2'b00) ? force_rresp :
                  ((mode == 1 && $urandom_range(0, 11) == 0) ? 2'b10 : 2'b00);
        rvalid  = 1;
        pend_ar = 0;
      end
      if (bvalid && bready) begin b_fire = 1; if (bresp != 2'b00) err_exp = 1; end
      if (rvalid && rready) begin r_fire = 1; if (rresp != 2'b00) err_exp = 1; end
      // ready values that will be sampled on the coming edge
      awready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      wready  = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      arready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (awvalid && aw_stall > 0) begin awready = 0; aw_stall--; end
      if (awvalid) aw_hi++;
      if (wvalid)  w_hi++;
      aw_wait = awvalid && !awready; aw_prev = awaddr;
      w_wait  = wvalid && !wready;   w_prev  = {wdata, wstrb};
      ar_wait = arvalid && !arready; ar_prev = araddr;
      if (awvalid && awready) begin
        n_aw++;
        chk("aw_is_write", cur_wr, 1'b1);
        chk("awaddr", awaddr, {cur_addr[28:2], 2'b00});
        chk("aw_attr", {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos},
            {4'h0, 8'h00, 3'b010, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0});
        have_aw = 1; s_awaddr = awaddr;
      end
      if (wvalid && wready) begin
        chk("wdata", wdata, {cur_data, cur_data});
        chk("wstrb", wstrb, cur_addr[2] ? {cur_be, 4'h0} : {4'h0, cur_be});
        chk("wlast", wlast, 1'b1);
        have_w = 1; s_wdata = wdata; s_wstrb = wstrb;
      end
      if (arvalid && arready) begin
        n_ar++;
        chk("ar_is_read", !cur_wr && cur_rd, 1'b1);
        chk("araddr", araddr, {cur_addr[28:2], 2'b00});
        chk("ar_attr", {arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos},
            {4'h0, 8'h00, 3'b010, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0});
        pend_ar = 1; s_araddr = araddr;
      end
    end
  end

  // ---------------- core driver ----------------------------------------------
  // Holds the request until XHLT drops (DONE), then releases it. lat counts
  // rising edges from the request cycle to the DONE cycle.
  task automatic do_access(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be, input bit chk_data,
                           output int lat, output logic [31:0] got);
    bit done;
    @(posedge CLK); #1;
    cur_wr = wr; cur_rd = rd; cur_addr = a; cur_data = d; cur_be = be;
    XWR = wr; XRD = rd; XADDR = a; XDATAO = d; XBE = be;
    lat = 0; done = 0; got = 'x;
    while (!done && lat < 100) begin
      @(posedge CLK); lat++;
      @(negedge CLK);
      if (!XHLT) done = 1;
    end
    chk("done_seen", done, 1'b1);
    if (done) begin
      got = XDATAI;
      chk("err", ERR, err_exp);
      if (!wr && chk_data) chk("xdatai", XDATAI, ref_read(a));
      if (wr) ref_write(a, d, be);
    end
    @(posedge CLK); #1;
    XWR = 0; XRD = 0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RESN = 0; slv_rst = 1; XRD = 0; XWR = 0;
    repeat (2) @(posedge CLK);
    #1;
    RESN = 1; slv_rst = 0; err_exp = 0;
  endtask

  initial begin
    int          lat;
    logic [31:0] got;
    int          op;
    bit          wr, rd;
    for (int i = 0; i < 256; i++) rmem[i] = 8'h00;
    for (int i = 0; i < 32; i++)  smem[i] = 64'h0;
    RESN = 0; slv_rst = 1; XRD = 0; XWR = 0; XADDR = 0; XDATAO = 0; XBE = 0;
    mode = 0; b_hold = 0; r_force_en = 0; r_force_data = 0; force_rresp = 0; aw_stall = 0;
    aw_hi = 0; w_hi = 0; n_b = 0; n_aw = 0; n_ar = 0; err_exp = 0;
    cur_wr = 0; cur_rd = 0; cur_addr = 0; cur_data = 0; cur_be = 0;

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_xdatai", XDATAI, 32'h0);
    chk("rst_xhlt_idle", XHLT, 1'b0);
    XRD = 1; #1;
    chk("rst_xhlt_req", XHLT, 1'b1);
    XRD = 0;
    RESN = 1; slv_rst = 0;

    // lane-high write; DONE is the 4th cycle counting the request cycle
    do_access(1, 0, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1, lat, got);
    chk("wr_latency", lat, 3);

    // lane selection on reads from a fixed 64-bit beat
    r_force_en = 1; r_force_data = 64'h1111_1111_2222_2222;
    do_access(0, 1, 32'h0000_0000, 32'h0, 4'h0, 0, lat, got);
    chk("rd_lane_lo", got, 32'h2222_2222);
    chk("rd_latency", lat, 3);
    do_access(0, 1, 32'h0000_0008, 32'h0, 4'h0, 0, lat, got);
    chk("rd_lane_lo8", got, 32'h2222_2222);
    do_access(0, 1, 32'h0000_000C, 32'h0, 4'h0, 0, lat, got);
    chk("rd_lane_hi", got, 32'h1111_1111);
    r_force_en = 0;

    // AW accepted 5 cycles late, W immediately
    aw_hi = 0; w_hi = 0; n_b = 0; aw_stall = 5;
    do_access(1, 0, 32'h0000_0020, 32'hCAFE_F00D, 4'h3, 1, lat, got);
    chk("stall_aw_cycles", aw_hi, 6);
    chk("stall_w_cycles", w_hi, 1);
    chk("stall_b_count", n_b, 1);

    // read and write together: write wins, no AR issued
    n_ar = 0; n_aw = 0;
    do_access(1, 1, 32'h0000_0044, 32'h0BAD_CAFE, 4'hA, 1, lat, got);
    chk("both_ar_count", n_ar, 0);
    chk("both_aw_count", n_aw, 1);
    chk("both_err", ERR, 1'b0);

    // randomized traffic with random stalls and occasional error responses
    mode = 1;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      wr = (op <= 3) || (op == 9);
      rd = (op >= 4);
      do_access(wr, rd, $urandom(), $urandom(), 4'($urandom_range(0, 15)), 1, lat, got);
    end
    mode = 0;

    // sticky error from a read SLVERR, cleared only by reset
    do_reset();
    force_rresp = 2'b10;
    do_access(0, 1, 32'h0000_0010, 32'h0, 4'h0, 1, lat, got);
    chk("err_set", ERR, 1'b1);
    force_rresp = 2'b00;
    do_access(1, 0, 32'h0000_0018, 32'h1234_5678, 4'hF, 1, lat, got);
    do_access(0, 1, 32'h0000_0018, 32'h0, 4'h0, 1, lat, got);
    chk("err_sticky", ERR, 1'b1);
    do_reset();
    chk("err_cleared", ERR, 1'b0);

    // reset while waiting for the write response
    b_hold = 1;
    @(posedge CLK); #1;
    cur_wr = 1; cur_rd = 0; cur_addr = 32'h0000_0030; cur_data = 32'h5555_AAAA; cur_be = 4'hF;
    XWR = 1; XRD = 0; XADDR = cur_addr; XDATAO = cur_data; XBE = cur_be;
    lat = 0;
    while (lat < 50) begin
      @(negedge CLK);
      if (bready) break;
      lat++;
    end
    chk("wresp_reached", bready, 1'b1);
    @(posedge CLK); #1;
    RESN = 0; slv_rst = 1;
    @(posedge CLK); #1;
    chk("midrst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    chk("midrst_xhlt_req", XHLT, 1'b1);
    XWR = 0; #1;
    chk("midrst_xhlt_idle", XHLT, 1'b0);
    @(posedge CLK); #1;
    RESN = 1; slv_rst = 0; b_hold = 0; err_exp = 0;
    repeat (2) @(posedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
